// File: rtl/dict_image_loader.sv
// Boot-time loader: fetches a dictionary image over the memory port, streams the values
// into three field dictionaries, then hands the port to the fetch controller as a pass-through.
module dict_image_loader #(
   parameter int          FIELD1_KEY_WIDTH = 3,
   parameter int          FIELD2_KEY_WIDTH = 5,
   parameter int          FIELD3_KEY_WIDTH = 8,
   parameter int          FIELD1_VAL_WIDTH = 7,
   parameter int          FIELD2_VAL_WIDTH = 10,
   parameter int          FIELD3_VAL_WIDTH = 15,
   parameter logic [31:0] BASE_ADDR        = 32'h0001_0000
) (
   input  logic                        clk,
   input  logic                        resetn,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [31:0]                 mem_req_addr,
   input  logic [31:0]                 mem_req_rdata,
   input  logic                        ctl_mem_req_valid,
   output logic                        ctl_mem_req_ready,
   input  logic [31:0]                 ctl_mem_req_addr,
   output logic [31:0]                 ctl_mem_req_rdata,
   output logic                        dict1_write_enable,
   output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
   output logic                        dict2_write_enable,
   output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
   output logic                        dict3_write_enable,
   output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
   output logic                        load_done
);

   typedef enum logic [2:0] {RST, HDR, D1, D2, D3, FIN, DONE} state_t;

   // Dictionary capacities; a key width of 8 or more never clamps an 8-bit count.
   localparam logic [8:0] CAP1 = (FIELD1_KEY_WIDTH >= 8) ? 9'd256 : 9'(1 << FIELD1_KEY_WIDTH);
   localparam logic [8:0] CAP2 = (FIELD2_KEY_WIDTH >= 8) ? 9'd256 : 9'(1 << FIELD2_KEY_WIDTH);
   localparam logic [8:0] CAP3 = (FIELD3_KEY_WIDTH >= 8) ? 9'd256 : 9'(1 << FIELD3_KEY_WIDTH);

   function automatic logic [8:0] clamp(input logic [7:0] c, input logic [8:0] cap);
      clamp = ({1'b0, c} > cap) ? cap : {1'b0, c};
   endfunction

   state_t      state, state_next;
   logic        req_valid_r;
   logic [31:0] req_addr_r;
   logic [8:0]  rem;
   logic [8:0]  e2_r, e3_r;
   logic [31:0] s2_r, s3_r;
   logic [8:0]  h_e1, h_e2, h_e3;
   logic [31:0] h_s2, h_s3;
   logic        resp, last_word;

   assign load_done = (state == DONE);
   assign resp      = req_valid_r && mem_req_ready;
   assign last_word = (rem == 9'd1);

   // Header decode: section starts use the raw counts, fetch lengths use the clamped ones.
   assign h_e1 = clamp(mem_req_rdata[7:0],   CAP1);
   assign h_e2 = clamp(mem_req_rdata[15:8],  CAP2);
   assign h_e3 = clamp(mem_req_rdata[23:16], CAP3);
   assign h_s2 = BASE_ADDR + 32'd4 + {22'd0, mem_req_rdata[7:0], 2'b00};
   assign h_s3 = h_s2 + {22'd0, mem_req_rdata[15:8], 2'b00};

   assign mem_req_valid     = load_done ? ctl_mem_req_valid : req_valid_r;
   assign mem_req_addr      = load_done ? ctl_mem_req_addr  : req_addr_r;
   assign ctl_mem_req_ready = load_done & mem_req_ready;
   assign ctl_mem_req_rdata = load_done ? mem_req_rdata : '0;

   always_ff @(posedge clk) begin
      if (!resetn) state <= RST;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RST:  state_next = HDR;
         HDR:  if (resp) begin
                  if      (h_e1 != '0) state_next = D1;
                  else if (h_e2 != '0) state_next = D2;
                  else if (h_e3 != '0) state_next = D3;
                  else                 state_next = FIN;
               end
         D1:   if (resp && last_word) begin
                  if      (e2_r != '0) state_next = D2;
                  else if (e3_r != '0) state_next = D3;
                  else                 state_next = FIN;
               end
         D2:   if (resp && last_word) state_next = (e3_r != '0) ? D3 : FIN;
         D3:   if (resp && last_word) state_next = FIN;
         FIN:  state_next = DONE;
         DONE: state_next = DONE;
         default: state_next = RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         req_valid_r        <= 1'b0;
         req_addr_r         <= '0;
         rem                <= '0;
         e2_r               <= '0;
         e3_r               <= '0;
         s2_r               <= '0;
         s3_r               <= '0;
         dict1_write_enable <= 1'b0;
         dict2_write_enable <= 1'b0;
         dict3_write_enable <= 1'b0;
         dict1_write_val    <= '0;
         dict2_write_val    <= '0;
         dict3_write_val    <= '0;
      end else begin
         dict1_write_enable <= 1'b0;
         dict2_write_enable <= 1'b0;
         dict3_write_enable <= 1'b0;
         unique case (state)
            RST: begin
               req_valid_r <= 1'b1;
               req_addr_r  <= BASE_ADDR;
            end
            HDR: if (resp) begin
               req_valid_r <= 1'b0;
               e2_r        <= h_e2;
               e3_r        <= h_e3;
               s2_r        <= h_s2;
               s3_r        <= h_s3;
               if (h_e1 != '0) begin
                  req_addr_r <= BASE_ADDR + 32'd4;
                  rem        <= h_e1;
               end else if (h_e2 != '0) begin
                  req_addr_r <= h_s2;
                  rem        <= h_e2;
               end else begin
                  req_addr_r <= h_s3;
                  rem        <= h_e3;
               end
            end
            D1, D2, D3: begin
               // Valid drops for exactly one cycle after each response, then re-arms.
               if (!req_valid_r) begin
                  req_valid_r <= 1'b1;
               end else if (resp) begin
                  req_valid_r <= 1'b0;
                  if (state == D1) begin
                     dict1_write_enable <= 1'b1;
                     dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                  end else if (state == D2) begin
                     dict2_write_enable <= 1'b1;
                     dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                  end else begin
                     dict3_write_enable <= 1'b1;
                     dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                  end
                  if (!last_word) begin
                     req_addr_r <= req_addr_r + 32'd4;
                     rem        <= rem - 9'd1;
                  end else if (state == D1 && e2_r != '0) begin
                     req_addr_r <= s2_r;
                     rem        <= e2_r;
                  end else begin
                     req_addr_r <= s3_r;
                     rem        <= e3_r;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dict_image_loader.md
# dict_image_loader

Boot-time sequencer and memory-port arbiter for the compressed-fetch path. Out of reset it owns the single memory port. It reads a dictionary image (one header word, then value words) from memory and streams the values into the three field dictionaries through their `dictN_write_enable`/`dictN_write_val` inputs. When the image is loaded it raises `load_done` and hands the memory port to the fetch controller as a pure pass-through. It sits between `controller` and the memory model.

## Interface
Parameters:
- `FIELD1_KEY_WIDTH`, default 3: key width of dict1; dict1 capacity is 2^3 = 8 entries.
- `FIELD2_KEY_WIDTH`, default 5: key width of dict2; capacity 32 entries.
- `FIELD3_KEY_WIDTH`, default 8: key width of dict3; capacity 256 entries.
- `FIELD1_VAL_WIDTH`, default 7: value width of dict1.
- `FIELD2_VAL_WIDTH`, default 10: value width of dict2.
- `FIELD3_VAL_WIDTH`, default 15: value width of dict3.
- `BASE_ADDR`, default 32'h0001_0000: byte address of the header word; word aligned.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory response strobe.
- `mem_req_addr`  out  32  memory byte address.
- `mem_req_rdata`  in  32  memory data, valid when `mem_req_ready`=1.
- `ctl_mem_req_valid`  in  1  request from the fetch controller.
- `ctl_mem_req_ready`  out  1  response strobe to the fetch controller.
- `ctl_mem_req_addr`  in  32  fetch controller address.
- `ctl_mem_req_rdata`  out  32  data to the fetch controller.
- `dict1_write_enable`  out  1  dict1 append strobe.
- `dict1_write_val`  out  FIELD1_VAL_WIDTH  dict1 value.
- `dict2_write_enable`  out  1  dict2 append strobe.
- `dict2_write_val`  out  FIELD2_VAL_WIDTH  dict2 value.
- `dict3_write_enable`  out  1  dict3 append strobe.
- `dict3_write_val`  out  FIELD3_VAL_WIDTH  dict3 value.
- `load_done`  out  1  image fully loaded; port handed over.

## Operation
Image format:
- Header at `BASE_ADDR`:
  - [7:0] = C1, raw entry count for dict1.
  - [15:8] = C2, raw entry count for dict2.
  - [23:16] = C3, raw entry count for dict3.
  - [31:24] ignored.
- Value words follow at `BASE_ADDR`+4, packed as C1 dict1 words, then C2 dict2 words, then C3 dict3 words.
- Each dictionary takes its value from `rdata[VAL_WIDTH-1:0]`; upper bits are ignored.

Clamping:
- Effective count Ek = min(Ck, 2^FIELDk_KEY_WIDTH).
- Only the first Ek words of each section are fetched. Excess words are skipped; they are never requested.
- Start addresses:
  - dict1 section: `BASE_ADDR`+4.
  - dict2 section: `BASE_ADDR`+4·(1+C1).
  - dict3 section: `BASE_ADDR`+4·(1+C1+C2).
- Address arithmetic is 32-bit and wraps modulo 2^32.

FSM states: RST, HDR, D1, D2, D3, FIN, DONE.
- RST is the state while `resetn`=0. It exits to HDR on the first cycle with `resetn`=1.
- HDR: fetch the header, latch C1..C3, go to the first section with Ek>0; if all Ek=0, go to FIN.
- Dk: fetch Ek words. Each response produces exactly one `dictk_write_enable` pulse. After the last word, go to the next nonzero section or to FIN.
- FIN: lasts one cycle, then DONE.
- DONE: terminal until reset.

Memory handshake (loader side):
- Assert `mem_req_valid` with a stable `mem_req_addr`, and hold both until `mem_req_ready`=1.
- `mem_req_rdata` is captured in the ready cycle.
- `mem_req_valid` is 0 in the following cycle, giving exactly one idle cycle between consecutive requests.

Arbitration:
- While `load_done`=0:
  - `ctl_mem_req_valid` is ignored.
  - `ctl_mem_req_ready`=0.
  - `ctl_mem_req_rdata`=0.
- While `load_done`=1, the port is a combinational pass-through:
  - `mem_req_valid` = `ctl_mem_req_valid`.
  - `mem_req_addr` = `ctl_mem_req_addr`.
  - `ctl_mem_req_ready` = `mem_req_ready`.
  - `ctl_mem_req_rdata` = `mem_req_rdata`.

Dictionary writes:
- `dictk_write_val` is registered from the response data.
- `dictk_write_enable` is a registered single-cycle pulse.
- At most one of the three enables is high in any cycle.
- Enables are never high in DONE.

## Timing
Reset values:
- `mem_req_valid`=0, `mem_req_addr`=0.
- All `dictk_write_enable`=0 and all `dictk_write_val`=0.
- `load_done`=0.
- `ctl_mem_req_ready`=0, `ctl_mem_req_rdata`=0.

Sequencing:
- Cycle 0 is the first cycle with `resetn`=1.
- `mem_req_valid`=1 with `mem_req_addr`=`BASE_ADDR` from cycle 1.
- If a response arrives in cycle N:
  - The matching `dictk_write_enable` is high in cycle N+1.
  - The next request is valid from cycle N+2.
- After the final response in cycle N:
  - The last write pulse is in cycle N+1; FIN is that same cycle.
  - `load_done`=1 from cycle N+2.
- All-zero header with response in cycle N: no write pulses, and `load_done`=1 from cycle N+2.
- Best-case load (ready in the first valid cycle) takes 2·(1+E1+E2+E3)+1 cycles from cycle 0 to `load_done`.

Boundary conditions:
- `resetn`=0 mid-load returns the FSM to RST and clears all counters. Loading restarts from the header. Already-written dictionary entries are cleared by the dictionaries' own reset.
- `mem_req_ready`=1 while `mem_req_valid`=0 during the load is ignored.

## Test plan
- Header C1=2, C2=1, C3=3; values 0x13, 0x33, 0x03, then 0x7FFF, 0x1, 0x2 -> dict1 gets 0x13, 0x33; dict2 gets 0x003; dict3 gets 0x7FFF, 0x0001, 0x0002. Addresses fetched are `BASE_ADDR` + 0, 4, …, 24 in order. `load_done` is high 2 cycles after the 7th ready.
- Header 0 -> no write pulses; only `BASE_ADDR` is fetched; `load_done`=1 at cycle N+2.
- C1=12, C2=0, C3=1 -> dict1 gets 8 writes from `BASE_ADDR`+4..+32; dict3 reads `BASE_ADDR`+52; words +36..+48 are never requested.
- Memory delays ready by 5 cycles per request -> `mem_req_addr` and `mem_req_valid` are stable while waiting; one idle valid-low cycle after each ready; write order unchanged.
- Before `load_done`, `ctl_mem_req_valid`=1 at `ctl_mem_req_addr`=0x100 -> `ctl_mem_req_ready` stays 0. After `load_done`, the same request appears on `mem_req_*` combinationally, and ready/rdata return in the same cycle.
- `resetn` pulsed low for 1 cycle after the 3rd write -> all outputs are at reset values in the following cycle; the header is re-fetched from cycle 1 after release; the full sequence completes.
